// File: rtl/frame_sequencer.sv
// Per-frame scheduler: on each VGA vertical-sync edge, issues map step, logic step, then commit.
// Optional FRAME_DIV_EN macro: start a sequence only on every FRAME_DIV-th accepted VS edge.
module frame_sequencer #(
  parameter int unsigned TIMEOUT_CYC   = 100000,
  parameter bit          VS_ACTIVE_LOW = 1'b1,
  parameter int unsigned FRAME_DIV     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vs,
  input  logic        pause,
  input  logic        map_done,
  input  logic        logic_done,
  output logic        map_step,
  output logic        logic_step,
  output logic        commit,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [7:0]  overrun_cnt,
  output logic        timeout_err
);

  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 2);
  localparam logic        VS_IDLE = VS_ACTIVE_LOW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAP_WAIT,
    ST_LOGIC_WAIT,
    ST_COMMIT
  } state_e;

  state_e          state_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            vs_meta_q, vs_sync_q, vs_hist_q;
  logic            map_step_q, logic_step_q, commit_q, busy_q, timeout_err_q;
  logic [15:0]     frame_cnt_q;
  logic [7:0]      overrun_cnt_q, overrun_cnt_d;
  logic            vs_edge_c, idle_edge_c, start_c;

  // Synchroniser and history flops park at the inactive level so reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_meta_q <= VS_IDLE;
      vs_sync_q <= VS_IDLE;
      vs_hist_q <= VS_IDLE;
    end else begin
      vs_meta_q <= vs;
      vs_sync_q <= vs_meta_q;
      vs_hist_q <= vs_sync_q;
    end
  end

  assign vs_edge_c     = (vs_sync_q != VS_IDLE) && (vs_hist_q == VS_IDLE);
  assign idle_edge_c   = (state_q == ST_IDLE) && vs_edge_c && !pause;
  assign overrun_cnt_d = (overrun_cnt_q == 8'hFF) ? overrun_cnt_q : overrun_cnt_q + 8'd1;

`ifdef FRAME_DIV_EN
  localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  logic [DIV_W-1:0] div_q;

  // Only accepted, non-paused IDLE edges move the divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (idle_edge_c) begin
      div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end
  end

  assign start_c = idle_edge_c && (div_q == DIV_LAST);
`else
  assign start_c = idle_edge_c;
`endif

  // Sequencing FSM; strobes default low and pulse for one cycle on the entering transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      to_cnt_q      <= '0;
      map_step_q    <= 1'b0;
      logic_step_q  <= 1'b0;
      commit_q      <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_cnt_q   <= '0;
      overrun_cnt_q <= '0;
    end else begin
      map_step_q   <= 1'b0;
      logic_step_q <= 1'b0;
      commit_q     <= 1'b0;

      if (vs_edge_c && (state_q != ST_IDLE)) begin
        overrun_cnt_q <= overrun_cnt_d;
      end

      case (state_q)
        ST_IDLE: begin
          if (start_c) begin
            state_q    <= ST_MAP_WAIT;
            map_step_q <= 1'b1;
            busy_q     <= 1'b1;
            to_cnt_q   <= '0;
          end
        end
        ST_MAP_WAIT: begin
          if (map_done) begin
            state_q      <= ST_LOGIC_WAIT;
            logic_step_q <= 1'b1;
            to_cnt_q     <= '0;
          end else if (to_cnt_q == TO_LAST) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        ST_LOGIC_WAIT: begin
          if (logic_done) begin
            state_q     <= ST_COMMIT;
            commit_q    <= 1'b1;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end else if (to_cnt_q == TO_LAST) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        ST_COMMIT: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign map_step    = map_step_q;
  assign logic_step  = logic_step_q;
  assign commit      = commit_q;
  assign busy        = busy_q;
  assign frame_cnt   = frame_cnt_q;
  assign overrun_cnt = overrun_cnt_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: vector table of frames plus hand-built corner sequences.
module tb_frame_sequencer;

  localparam int unsigned TO = 16;
`ifdef FRAME_DIV_EN
  localparam int PULSES = 2;
`else
  localparam int PULSES = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b1;
  logic        pause = 1'b0;
  logic        map_done = 1'b1;
  logic        logic_done = 1'b1;
  logic        map_step, logic_step, commit, busy, timeout_err;
  logic [15:0] frame_cnt;
  logic [7:0]  overrun_cnt;

  always #5 clk = ~clk;

  frame_sequencer #(
    .TIMEOUT_CYC  (TO),
    .VS_ACTIVE_LOW(1'b1),
    .FRAME_DIV    (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vs         (vs),
    .pause      (pause),
    .map_done   (map_done),
    .logic_done (logic_done),
    .map_step   (map_step),
    .logic_step (logic_step),
    .commit     (commit),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .overrun_cnt(overrun_cnt),
    .timeout_err(timeout_err)
  );

  // Strobe monitor: counts and cycle stamps taken on the falling edge.
  int cyc = 0, n_map = 0, n_logic = 0, n_commit = 0, n_busy = 0;
  int map_cyc = 0, logic_cyc = 0, commit_cyc = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (map_step)   begin n_map    <= n_map + 1;    map_cyc    <= cyc; end
    if (logic_step) begin n_logic  <= n_logic + 1;  logic_cyc  <= cyc; end
    if (commit)     begin n_commit <= n_commit + 1; commit_cyc <= cyc; end
    if (busy)       n_busy <= n_busy + 1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One active-low VS pulse; returns the cycle stamp of the falling edge.
  task automatic pulse(output int fall);
    vs = 1'b0;
    fall = cyc;
    wait_cyc(2);
    vs = 1'b1;
    wait_cyc(8);
  endtask

  // Enough pulses to start one sequence (divider-aware).
  task automatic frame(output int fall);
    for (int i = 0; i < PULSES; i++) pulse(fall);
  endtask

  typedef struct {
    logic pause;
    int   exp_seq;
  } vec_t;

  vec_t        vecs[8];
  int          f, s_map, s_logic, s_commit, s_busy;
  logic [15:0] exp_fc;

  task automatic snap();
    s_map = n_map; s_logic = n_logic; s_commit = n_commit; s_busy = n_busy;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1};
    vecs[1] = '{1'b0, 1};
    vecs[2] = '{1'b0, 1};
    vecs[3] = '{1'b1, 0};
    vecs[4] = '{1'b1, 0};
    vecs[5] = '{1'b1, 0};
    vecs[6] = '{1'b1, 0};
    vecs[7] = '{1'b0, 1};
    exp_fc = 16'd0;

    // Reset state
    wait_cyc(3);
    chk("reset busy", int'(busy), 0);
    chk("reset map_step", int'(map_step), 0);
    chk("reset frame_cnt", int'(frame_cnt), 0);
    chk("reset overrun_cnt", int'(overrun_cnt), 0);
    chk("reset timeout_err", int'(timeout_err), 0);
    rst_n = 1'b1;
    wait_cyc(6);
    chk("no edge after reset", n_map, 0);

    // Table-driven frames with both dones held high
    for (int i = 0; i < 8; i++) begin
      pause = vecs[i].pause;
      snap();
      frame(f);
      exp_fc = exp_fc + 16'(vecs[i].exp_seq);
      chk($sformatf("v%0d map count", i), n_map - s_map, vecs[i].exp_seq);
      chk($sformatf("v%0d logic count", i), n_logic - s_logic, vecs[i].exp_seq);
      chk($sformatf("v%0d commit count", i), n_commit - s_commit, vecs[i].exp_seq);
      chk($sformatf("v%0d busy cycles", i), n_busy - s_busy, 3 * vecs[i].exp_seq);
      chk($sformatf("v%0d frame_cnt", i), int'(frame_cnt), int'(exp_fc));
      if (vecs[i].exp_seq != 0) begin
        chk($sformatf("v%0d map latency", i), map_cyc - f, 3);
        chk($sformatf("v%0d logic after map", i), logic_cyc - map_cyc, 1);
        chk($sformatf("v%0d commit after logic", i), commit_cyc - logic_cyc, 1);
      end
    end
    pause = 1'b0;
    chk("table overrun_cnt", int'(overrun_cnt), 0);

    // Timeout in MAP_WAIT, then recovery with done high
    chk("pre-timeout err", int'(timeout_err), 0);
    map_done = 1'b0;
    snap();
    frame(f);
    wait_cyc(15);
    chk("timeout err set", int'(timeout_err), 1);
    chk("timeout busy low", int'(busy), 0);
    chk("timeout busy cycles", n_busy - s_busy, 15);
    chk("timeout logic count", n_logic - s_logic, 0);
    chk("timeout commit count", n_commit - s_commit, 0);
    chk("timeout frame_cnt", int'(frame_cnt), int'(exp_fc));
    map_done = 1'b1;
    snap();
    frame(f);
    exp_fc = exp_fc + 16'd1;
    chk("recovery commit", n_commit - s_commit, 1);
    chk("recovery frame_cnt", int'(frame_cnt), int'(exp_fc));
    chk("timeout err sticky", int'(timeout_err), 1);

    // Slow logic_done with a second VS edge landing in LOGIC_WAIT
    logic_done = 1'b0;
    for (int i = 0; i < PULSES - 1; i++) pulse(f);
    snap();
    vs = 1'b0; wait_cyc(2); vs = 1'b1; wait_cyc(4);
    vs = 1'b0; wait_cyc(2); vs = 1'b1; wait_cyc(4);
    logic_done = 1'b1;
    wait_cyc(10);
    exp_fc = exp_fc + 16'd1;
    chk("overrun count 1", int'(overrun_cnt), 1);
    chk("overrun single commit", n_commit - s_commit, 1);
    chk("overrun single map", n_map - s_map, 1);
    chk("overrun busy cycles", n_busy - s_busy, 11);
    chk("overrun frame_cnt", int'(frame_cnt), int'(exp_fc));

    // Hammer VS while sequences stall to saturate the overrun counter
    map_done = 1'b0;
    snap();
    repeat (600) begin
      vs = 1'b0; wait_cyc(1);
      vs = 1'b1; wait_cyc(1);
    end
    wait_cyc(25);
    chk("overrun saturates", int'(overrun_cnt), 255);
    chk("saturation no commit", n_commit - s_commit, 0);
    chk("saturation frame_cnt", int'(frame_cnt), int'(exp_fc));
    map_done = 1'b1;

    // Reset while waiting in LOGIC_WAIT
    logic_done = 1'b0;
    for (int i = 0; i < PULSES - 1; i++) pulse(f);
    vs = 1'b0; wait_cyc(2); vs = 1'b1; wait_cyc(4);
    chk("in LOGIC_WAIT busy", int'(busy), 1);
    snap();
    rst_n = 1'b0;
    #1;
    chk("mid reset busy", int'(busy), 0);
    chk("mid reset strobes", int'({map_step, logic_step, commit}), 0);
    chk("mid reset frame_cnt", int'(frame_cnt), 0);
    chk("mid reset overrun_cnt", int'(overrun_cnt), 0);
    chk("mid reset timeout_err", int'(timeout_err), 0);
    wait_cyc(2);
    rst_n = 1'b1;
    logic_done = 1'b1;
    wait_cyc(10);
    chk("aborted no commit", n_commit - s_commit, 0);
    chk("no spurious edge", n_map - s_map, 0);
    exp_fc = 16'd0;

    // Frame counter wrap from a preloaded 0xFFFF
    force dut.frame_cnt_q = 16'hFFFF;
    wait_cyc(1);
    release dut.frame_cnt_q;
    wait_cyc(1);
    chk("preload frame_cnt", int'(frame_cnt), 16'hFFFF);
    snap();
    frame(f);
    chk("wrap frame_cnt", int'(frame_cnt), 0);
    chk("wrap commit", n_commit - s_commit, 1);

`ifdef FRAME_DIV_EN
    // Divider phase: sequences on accepted pulses 2, 4, 6; paused pulse in between
    begin
      logic pz[7];
      int   exp_cum[7];
      pz      = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      exp_cum = '{0, 1, 1, 1, 2, 2, 3};
      snap();
      for (int i = 0; i < 7; i++) begin
        pause = pz[i];
        pulse(f);
        chk($sformatf("div pulse %0d seq", i), n_map - s_map, exp_cum[i]);
      end
      pause = 1'b0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
